// File: rtl/qeip_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM cell between two masters.
// Tracks one outstanding read per requester with a back-pressurable response slot.
module qeip_sram_arbiter #(
    parameter int BW_INDEX = 14,
    parameter int WIDTH = 32,
    localparam int BW_BYTE_WEN = WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rstnn,
    input  logic                   rq0_req,
    input  logic                   rq0_write,
    input  logic [BW_INDEX-1:0]    rq0_index,
    input  logic [BW_BYTE_WEN-1:0] rq0_wstrb,
    input  logic [WIDTH-1:0]       rq0_wdata,
    output logic                   rq0_ready,
    output logic                   rq0_rvalid,
    output logic [WIDTH-1:0]       rq0_rdata,
    input  logic                   rq0_rready,
    input  logic                   rq1_req,
    input  logic                   rq1_write,
    input  logic [BW_INDEX-1:0]    rq1_index,
    input  logic [BW_BYTE_WEN-1:0] rq1_wstrb,
    input  logic [WIDTH-1:0]       rq1_wdata,
    output logic                   rq1_ready,
    output logic                   rq1_rvalid,
    output logic [WIDTH-1:0]       rq1_rdata,
    input  logic                   rq1_rready,
    output logic [BW_INDEX-1:0]    cell_index,
    output logic                   cell_enable,
    output logic                   cell_wenable,
    output logic [BW_BYTE_WEN-1:0] cell_wenable_byte,
    output logic [WIDTH-1:0]       cell_wdata,
    output logic                   cell_renable,
    input  logic [WIDTH-1:0]       cell_rdata
);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_INFLIGHT,
        RD_HOLD
    } rd_state_t;

    rd_state_t        state_q [2];
    rd_state_t        state_d [2];
    logic [WIDTH-1:0] rsp_data [2];
    logic             last_grant;

    logic [1:0] req;
    logic [1:0] write;
    logic [1:0] rready;
    logic [1:0] elig;
    logic [1:0] grant;
    logic [1:0] rd_acc;
    logic       sel;

    assign req    = {rq1_req, rq0_req};
    assign write  = {rq1_write, rq0_write};
    assign rready = {rq1_rready, rq0_rready};

    // A read may issue only when its response slot is free or drains this cycle.
    always_comb begin
        elig = 2'b00;
        for (int n = 0; n < 2; n++) begin
            elig[n] = req[n] & (write[n]
                | (state_q[n] == RD_IDLE)
                | ((state_q[n] == RD_HOLD) & rready[n]));
        end
    end

    // Grants are masked during reset so every output is 0 while rstnn is low.
    always_comb begin
        grant = 2'b00;
        if (rstnn) begin
            unique case (elig)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign sel    = grant[1];
    assign rd_acc = grant & ~write;

    assign cell_enable  = |grant;
    assign cell_wenable = cell_enable & write[sel];
    assign cell_renable = cell_enable & ~write[sel];
    assign cell_index   = !cell_enable ? '0 : (sel ? rq1_index : rq0_index);
    assign cell_wdata   = !cell_enable ? '0 : (sel ? rq1_wdata : rq0_wdata);
    assign cell_wenable_byte = !cell_wenable ? '0
                             : (sel ? rq1_wstrb : rq0_wstrb);

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            state_d[n] = state_q[n];
            unique case (state_q[n])
                RD_IDLE:
                    if (rd_acc[n]) state_d[n] = RD_INFLIGHT;
                RD_INFLIGHT:
                    state_d[n] = RD_HOLD;
                RD_HOLD:
                    if (rready[n])
                        state_d[n] = rd_acc[n] ? RD_INFLIGHT : RD_IDLE;
                default:
                    state_d[n] = RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            for (int n = 0; n < 2; n++) begin
                state_q[n]  <= RD_IDLE;
                rsp_data[n] <= '0;
            end
            last_grant <= 1'b1;
        end else begin
            for (int n = 0; n < 2; n++) begin
                state_q[n] <= state_d[n];
                if (state_q[n] == RD_INFLIGHT) rsp_data[n] <= cell_rdata;
            end
            if (|grant) last_grant <= grant[1];
        end
    end

    assign rq0_ready  = grant[0];
    assign rq1_ready  = grant[1];
    assign rq0_rvalid = (state_q[0] == RD_HOLD);
    assign rq1_rvalid = (state_q[1] == RD_HOLD);
    assign rq0_rdata  = rsp_data[0];
    assign rq1_rdata  = rsp_data[1];

endmodule

// File: tb/tb_qeip_sram_arbiter.sv
// Scoreboard bench for qeip_sram_arbiter with a behavioural SRAM cell.
// Stimulus pushes expected read data; a monitor pops on rvalid & rready.
module tb_qeip_sram_arbiter;
    localparam int BI = 14;
    localparam int W  = 32;
    localparam int BB = W / 8;

    logic clk = 1'b0;
    logic rstnn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    req;
    logic [1:0]    wr;
    logic [1:0]    rready;
    logic [BI-1:0] idx [2];
    logic [BB-1:0] wstrb [2];
    logic [W-1:0]  wdata [2];
    logic [1:0]    ready;
    logic [1:0]    rvalid;
    logic [W-1:0]  rdata [2];

    logic [BI-1:0] cell_index;
    logic          cell_enable;
    logic          cell_wenable;
    logic [BB-1:0] cell_wenable_byte;
    logic [W-1:0]  cell_wdata;
    logic          cell_renable;
    logic [W-1:0]  cell_rdata;

    qeip_sram_arbiter #(.BW_INDEX(BI), .WIDTH(W)) dut (
        .clk(clk), .rstnn(rstnn),
        .rq0_req(req[0]), .rq0_write(wr[0]), .rq0_index(idx[0]),
        .rq0_wstrb(wstrb[0]), .rq0_wdata(wdata[0]),
        .rq0_ready(ready[0]), .rq0_rvalid(rvalid[0]),
        .rq0_rdata(rdata[0]), .rq0_rready(rready[0]),
        .rq1_req(req[1]), .rq1_write(wr[1]), .rq1_index(idx[1]),
        .rq1_wstrb(wstrb[1]), .rq1_wdata(wdata[1]),
        .rq1_ready(ready[1]), .rq1_rvalid(rvalid[1]),
        .rq1_rdata(rdata[1]), .rq1_rready(rready[1]),
        .cell_index(cell_index), .cell_enable(cell_enable),
        .cell_wenable(cell_wenable),
        .cell_wenable_byte(cell_wenable_byte),
        .cell_wdata(cell_wdata), .cell_renable(cell_renable),
        .cell_rdata(cell_rdata)
    );

    logic [W-1:0] mem [0:(1<<BI)-1];
    always @(posedge clk) begin
        if (cell_enable && cell_wenable)
            for (int b = 0; b < BB; b++)
                if (cell_wenable_byte[b])
                    mem[cell_index][8*b +: 8] <= cell_wdata[8*b +: 8];
        if (cell_renable) cell_rdata <= mem[cell_index];
    end

    int n_checks = 0;
    int n_fail = 0;
    int rsp_cnt [2];
    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstnn) begin
            if (rvalid[0] && rready[0]) begin
                check("rq0 rsp expected", 64'(q0.size() != 0), 1);
                if (q0.size() != 0) check("rq0 rdata", rdata[0], q0.pop_front());
                rsp_cnt[0]++;
            end
            if (rvalid[1] && rready[1]) begin
                check("rq1 rsp expected", 64'(q1.size() != 0), 1);
                if (q1.size() != 0) check("rq1 rdata", rdata[1], q1.pop_front());
                rsp_cnt[1]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n, input bit w, input int i,
                         input logic [W-1:0] d, input logic [BB-1:0] s);
        logic [BI-1:0] iv;
        iv = i[BI-1:0];
        req[n] = 1'b1;
        wr[n] = w;
        idx[n] = iv;
        wdata[n] = d;
        wstrb[n] = s;
    endtask

    int k0, k1, c0, c1;
    bit exp_g;
    logic [W-1:0] v;

    initial begin
        req = 2'b00; wr = 2'b00; rready = 2'b11;
        rsp_cnt[0] = 0; rsp_cnt[1] = 0;
        for (int i = 0; i < (1 << BI); i++) mem[i] = '0;
        cell_rdata = '0;
        drive(0, 1'b1, 100, 32'h0000_0100, 4'hF);
        drive(1, 1'b1, 101, 32'h0000_0101, 4'hF);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready", ready, 2'b00);
        check("reset cell_enable", cell_enable, 0);
        check("reset cell_wenable", cell_wenable, 0);
        check("reset cell_renable", cell_renable, 0);
        check("reset cell_index", cell_index, 0);
        check("reset cell_wdata", cell_wdata, 0);
        check("reset rvalid", rvalid, 2'b00);
        tick();
        rstnn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("tie grant", ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        req = 2'b00;

        drive(0, 1'b1, 5, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        check("write grant", ready, 2'b01);
        check("write wenable", cell_wenable, 1);
        tick();
        drive(0, 1'b0, 5, '0, '0);
        @(negedge clk);
        check("read grant", ready, 2'b01);
        check("read renable T", cell_renable, 1);
        check("read index", cell_index, 5);
        check("read no wbyte", cell_wenable_byte, 0);
        q0.push_back(32'hDEADBEEF);
        tick();
        req = 2'b00;
        @(negedge clk);
        check("rvalid T+1", rvalid[0], 0);
        tick();
        @(negedge clk);
        check("rvalid T+2", rvalid[0], 1);
        tick();

        drive(0, 1'b1, 7, 32'h11223344, 4'hF);
        tick();
        drive(0, 1'b1, 7, 32'hAABBCCDD, 4'b0101);
        @(negedge clk);
        check("byte strobe", cell_wenable_byte, 4'b0101);
        tick();
        drive(0, 1'b0, 7, '0, '0);
        @(negedge clk);
        q0.push_back(32'h11BB33DD);
        tick();
        req = 2'b00;
        repeat (3) tick();

        rready[1] = 1'b0;
        drive(1, 1'b0, 5, '0, '0);
        @(negedge clk);
        check("bp read grant", ready, 2'b10);
        q1.push_back(32'hDEADBEEF);
        tick();
        req = 2'b00;
        tick();
        for (int c = 0; c < 5; c++) begin
            req = 2'b00;
            if (c == 1) drive(1, 1'b1, 9, 32'h0BADF00D, 4'hF);
            else drive(1, 1'b0, 9, '0, '0);
            if (c == 0) drive(0, 1'b0, 7, '0, '0);
            @(negedge clk);
            check("bp grant", ready,
                  (c == 0) ? 2'b01 : ((c == 1) ? 2'b10 : 2'b00));
            check("bp rvalid", rvalid[1], 1);
            check("bp rdata stable", rdata[1], 32'hDEADBEEF);
            if (c == 0) q0.push_back(32'h11BB33DD);
            tick();
        end
        req = 2'b00;
        rready[1] = 1'b1;
        drive(1, 1'b0, 9, '0, '0);
        @(negedge clk);
        check("bp release grant", ready, 2'b10);
        q1.push_back(32'h0BADF00D);
        tick();
        req = 2'b00;
        repeat (4) tick();

        for (int i = 0; i < 12; i++) begin
            drive(0, 1'b1, 20 + i, 32'hC0DE0000 + 32'(20 + i), 4'hF);
            tick();
        end
        req = 2'b00;
        tick();
        k0 = 0; k1 = 0; exp_g = 1'b1;
        c0 = rsp_cnt[0]; c1 = rsp_cnt[1];
        for (int c = 0; c < 12; c++) begin
            drive(0, 1'b0, 20 + 2 * k0, '0, '0);
            drive(1, 1'b0, 21 + 2 * k1, '0, '0);
            @(negedge clk);
            check("contention grant", ready, exp_g ? 2'b10 : 2'b01);
            check("contention busy", cell_enable, 1);
            if (c >= 2) check("contention rvalid", rvalid[exp_g], 1);
            if (exp_g) begin
                v = 32'hC0DE0000 + 32'(21 + 2 * k1);
                q1.push_back(v);
                k1++;
            end else begin
                v = 32'hC0DE0000 + 32'(20 + 2 * k0);
                q0.push_back(v);
                k0++;
            end
            exp_g = ~exp_g;
            tick();
        end
        req = 2'b00;
        repeat (4) tick();
        check("rq0 responses", rsp_cnt[0] - c0, 6);
        check("rq1 responses", rsp_cnt[1] - c1, 6);

        drive(0, 1'b0, 5, '0, '0);
        @(negedge clk);
        check("mid-reset read grant", ready, 2'b01);
        q0.push_back(32'hDEADBEEF);
        tick();
        req = 2'b00;
        q0.delete();
        q1.delete();
        rstnn = 1'b0;
        #1;
        check("mid-reset rvalid", rvalid, 2'b00);
        check("mid-reset rdata", rdata[0], 0);
        tick();
        tick();
        rstnn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("no stale rsp", rvalid, 2'b00);
            tick();
        end
        drive(0, 1'b1, 200, 32'h1, 4'hF);
        drive(1, 1'b1, 201, 32'h2, 4'hF);
        @(negedge clk);
        check("post-reset tie", ready, 2'b01);
        tick();
        req = 2'b00;
        tick();

        check("rq0 queue drained", q0.size(), 0);
        check("rq1 queue drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/qeip_sram_arbiter.md
# qeip_sram_arbiter

Two-requester arbiter that shares one single-port SRAM cell (1R1W cell used as single-port, synchronous read, byte write enables) between two native-interface masters, e.g. the AXI SRAM controller path and the QEIP state-vector engine. It grants at most one cell access per cycle using round-robin priority. It tracks one outstanding read per requester and returns read data through a registered, back-pressurable response slot.

## Interface
- BW_INDEX, 14, word index width of the cell.
- WIDTH, 32, data width; must be a multiple of 8. BW_BYTE_WEN = WIDTH/8 is derived, not overridable.

Ports (N = 0, 1):
- clk  input  1  clock.
- rstnn  input  1  asynchronous, active-low reset.
- rqN_req  input  1  access request.
- rqN_write  input  1  1 = write, 0 = read; valid with rqN_req.
- rqN_index  input  BW_INDEX  word index.
- rqN_wstrb  input  BW_BYTE_WEN  byte enables for a write.
- rqN_wdata  input  WIDTH  write data.
- rqN_ready  output  1  grant; the access is accepted when rqN_req and rqN_ready are both 1.
- rqN_rvalid  output  1  read response valid.
- rqN_rdata  output  WIDTH  read response data.
- rqN_rready  input  1  response accept.
- cell_index  output  BW_INDEX  index of the cell access.
- cell_enable  output  1  cell access this cycle.
- cell_wenable  output  1  write strobe.
- cell_wenable_byte  output  BW_BYTE_WEN  byte write enables.
- cell_wdata  output  WIDTH  write data.
- cell_renable  output  1  read strobe.
- cell_rdata  input  WIDTH  synchronous read data, valid the cycle after cell_renable.

## Operation
- Eligibility:
  - A write from requester N is always eligible.
  - A read from requester N is eligible only when rd_state_N = IDLE, or rd_state_N = HOLD with rqN_rready = 1 in the same cycle.
- Arbitration:
  - Combinational, each cycle.
  - If only one requester is eligible, that requester is granted.
  - If both are eligible, the requester not in last_grant is granted.
  - last_grant is updated on every accepted transfer. Its reset value is 1, so rq0 wins the first tie.
- rqN_ready is 1 only for the granted requester. It is never 1 for both requesters, and never 1 for an ineligible request.
- Cell drive:
  - When a grant exists: cell_enable = 1; cell_wenable = write; cell_renable = !write; index, wdata and byte enables are muxed from the winner; cell_wenable_byte = wstrb for a write, otherwise 0.
  - With no grant, all cell outputs are 0.
- Per-requester read FSM, rd_state_N:
  - IDLE → INFLIGHT on an accepted read.
  - INFLIGHT → HOLD unconditionally on the next cycle, capturing cell_rdata into rsp_data_N.
  - HOLD → IDLE on rqN_rvalid & rqN_rready with no new read accepted that cycle.
  - HOLD → INFLIGHT on rqN_rvalid & rqN_rready with a new read accepted in the same cycle.
- Response outputs: rqN_rvalid = (rd_state_N == HOLD); rqN_rdata = rsp_data_N.
- Writes do not interact with the read FSM. A requester in INFLIGHT or HOLD may still be granted writes.
- Write-then-read ordering is preserved because accesses to the cell are serialized.
- Reset: async assertion forces rd_state_N = IDLE, clears rsp_data_N and sets last_grant = 1. Every output goes to 0 at once, and any in-flight read is discarded.

## Timing
- Grant is combinational from rqN_req, rqN_write and state (same cycle). There is no combinational path from cell_rdata to any output.
- Read latency: read accepted at cycle T → cell_renable at T → cell_rdata at T+1 → rqN_rvalid = 1 at T+2.
- Read throughput: one read per 2 cycles per requester with rqN_rready held at 1 (accept at T+2 together with response pop). Two requesters alternating reads reach one cell access per cycle.
- Write latency: the cell is written at the rising edge ending the accept cycle.
- rqN_rdata is stable while rqN_rvalid = 1 and rqN_rready = 0.

## Test plan
- Reset: hold rstnn = 0 with both requests asserted → all outputs 0. After release, with rq0 and rq1 both requesting writes, rq0 is granted first, then rq1, then alternating.
- Single read: rq0 writes 0xDEADBEEF with wstrb 4'hF to index 5, then reads index 5 → cell_renable at T, rq0_rvalid at T+2 with rq0_rdata = 0xDEADBEEF.
- Byte strobe: write 0x11223344 with wstrb 4'hF, then 0xAABBCCDD with wstrb 4'b0101 to index 7 → read returns 0x11BB33DD.
- Backpressure: rq1 read completes while rq1_rready is held 0 for 5 cycles → rq1_rvalid stays 1 with stable data, and rq1 read requests get no ready. Meanwhile rq1 writes and rq0 reads are still granted.
- Contention: both requesters issue continuous reads with rready = 1 → the cell is busy every cycle, grants alternate rq0/rq1, and each requester sees a response every 2 cycles with correct data.
- Mid-read reset: assert rstnn at T+1 after an rq0 read is accepted → rq0_rvalid = 0 immediately. After release, no stale response is delivered.
